// File: rtl/lives_manager_if.sv
// rtl/lives_manager_if.sv - game-control / life-status bundle for lives_manager
//
// Purpose: groups the game-control pulses and the registered life status
// into one bundle. The master (game logic) drives the pulses; the slave
// (lives_manager) returns the status.
// Signals:
//   start      : one-cycle request to begin or restart a game
//   hit        : one-cycle pulse, player ship struck
//   frame_tick : one-cycle pulse per video frame
//   award_life : one-cycle bonus-life pulse (only when EXTRA_LIFE_EN is defined)
//   lives      : current life count
//   game_over  : high while the game is over
//   invuln     : high while post-hit invulnerability is active
//   life_lost  : one-cycle pulse per accepted hit
// Macro: EXTRA_LIFE_EN adds award_life.

interface lives_manager_if;
    logic       start;
    logic       hit;
    logic       frame_tick;
`ifdef EXTRA_LIFE_EN
    logic       award_life;
`endif
    logic [2:0] lives;
    logic       game_over;
    logic       invuln;
    logic       life_lost;

`ifdef EXTRA_LIFE_EN
    modport master (output start, hit, frame_tick, award_life,
                    input  lives, game_over, invuln, life_lost);
    modport slave  (input  start, hit, frame_tick, award_life,
                    output lives, game_over, invuln, life_lost);
`else
    modport master (output start, hit, frame_tick,
                    input  lives, game_over, invuln, life_lost);
    modport slave  (input  start, hit, frame_tick,
                    output lives, game_over, invuln, life_lost);
`endif
endinterface

// File: rtl/lives_manager.sv
// rtl/lives_manager.sv - player life counter with post-hit invulnerability window
//
// Purpose: tracks the player's remaining lives through the game states
// READY, PLAY, INVULN and OVER. A hit in PLAY costs one life and opens an
// invulnerability window lasting INVULN_FRAMES frame_tick pulses; losing
// the last life ends the game until start is pulsed again.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : lives_manager_if.slave (start, hit, frame_tick, [award_life] in;
//           lives, game_over, invuln, life_lost out, all registered)
// Parameters: INIT_LIVES (1..7), INVULN_FRAMES (1..255)
// Macro: EXTRA_LIFE_EN enables award_life (saturating +1 in PLAY/INVULN).

module lives_manager #(
    parameter int INIT_LIVES    = 3,
    parameter int INVULN_FRAMES = 60
) (
    input  logic            clk,
    input  logic            reset,
    lives_manager_if.slave  bus
);

    typedef enum logic [1:0] {
        READY  = 2'd0,
        PLAY   = 2'd1,
        INVULN = 2'd2,
        OVER   = 2'd3
    } state_t;

    localparam logic [2:0] LIVES_INIT = 3'(INIT_LIVES);
    localparam logic [2:0] LIVES_MAX  = 3'd7;
    localparam logic [7:0] CNT_INIT   = 8'(INVULN_FRAMES);

    state_t     state_q, state_d;
    logic [2:0] lives_q, lives_d;
    logic [7:0] cnt_q, cnt_d;
    logic       game_over_q, game_over_d;
    logic       invuln_q, invuln_d;
    logic       life_lost_q, life_lost_d;
    logic       award;

`ifdef EXTRA_LIFE_EN
    assign award = bus.award_life;
`else
    assign award = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= READY;
            lives_q     <= LIVES_INIT;
            cnt_q       <= 8'd0;
            game_over_q <= 1'b0;
            invuln_q    <= 1'b0;
            life_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            cnt_q       <= cnt_d;
            game_over_q <= game_over_d;
            invuln_q    <= invuln_d;
            life_lost_q <= life_lost_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        cnt_d       = cnt_q;
        life_lost_d = 1'b0;

        unique case (state_q)
            READY: begin
                if (bus.start) begin
                    state_d = PLAY;
                    lives_d = LIVES_INIT;
                end
            end

            PLAY: begin
                // A frame_tick coinciding with the hit is not counted: the
                // counter is simply loaded with the full window.
                if (bus.hit) begin
                    life_lost_d = 1'b1;
                    if (award) begin
                        // Bonus cancels the loss, so the game can never end here.
                        state_d = INVULN;
                        cnt_d   = CNT_INIT;
                    end else if (lives_q <= 3'd1) begin
                        state_d = OVER;
                        lives_d = 3'd0;
                        cnt_d   = 8'd0;
                    end else begin
                        state_d = INVULN;
                        lives_d = lives_q - 3'd1;
                        cnt_d   = CNT_INIT;
                    end
                end else if (award && lives_q != LIVES_MAX) begin
                    lives_d = lives_q + 3'd1;
                end
            end

            INVULN: begin
                if (award && lives_q != LIVES_MAX) begin
                    lives_d = lives_q + 3'd1;
                end
                if (bus.frame_tick) begin
                    if (cnt_q <= 8'd1) begin
                        state_d = PLAY;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end

            OVER: begin
                lives_d = 3'd0;
                if (bus.start) begin
                    state_d = PLAY;
                    lives_d = LIVES_INIT;
                end
            end

            default: begin
                state_d = READY;
                lives_d = LIVES_INIT;
                cnt_d   = 8'd0;
            end
        endcase

        // Flags follow the next state so they are registered alongside it.
        game_over_d = (state_d == OVER);
        invuln_d    = (state_d == INVULN);
    end

    assign bus.lives     = lives_q;
    assign bus.game_over = game_over_q;
    assign bus.invuln    = invuln_q;
    assign bus.life_lost = life_lost_q;

endmodule

// File: tb/tb_lives_manager.sv
// tb/tb_lives_manager.sv - directed self-checking bench for lives_manager

module tb_lives_manager;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    lives_manager_if lm_if ();

    lives_manager #(
        .INIT_LIVES   (3),
        .INVULN_FRAMES(60)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (lm_if.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input int lv, input int go, input int inv, input int ll);
        check({tag, ".lives"},     32'(lm_if.lives),     32'(lv));
        check({tag, ".game_over"}, 32'(lm_if.game_over), 32'(go));
        check({tag, ".invuln"},    32'(lm_if.invuln),    32'(inv));
        check({tag, ".life_lost"}, 32'(lm_if.life_lost), 32'(ll));
    endtask

    // Advance one rising edge; outputs are sampled 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        lm_if.start      = 1'b0;
        lm_if.hit        = 1'b0;
        lm_if.frame_tick = 1'b0;
`ifdef EXTRA_LIFE_EN
        lm_if.award_life = 1'b0;
`endif
    endtask

    task automatic pulse_start();
        lm_if.start = 1'b1;
        step();
        lm_if.start = 1'b0;
    endtask

    task automatic pulse_hit();
        lm_if.hit = 1'b1;
        step();
        lm_if.hit = 1'b0;
    endtask

    // Each tick is followed by an idle cycle, which must not count.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            lm_if.frame_tick = 1'b1;
            step();
            lm_if.frame_tick = 1'b0;
            step();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        check_all("reset", 3, 0, 0, 0);

        pulse_hit();
        check_all("ready_hit", 3, 0, 0, 0);

        pulse_start();
        check_all("start", 3, 0, 0, 0);
        pulse_start();
        check_all("start_in_play", 3, 0, 0, 0);

        pulse_hit();
        check_all("hit1", 2, 0, 1, 1);
        step();
        check("hit1.pulse_width", 32'(lm_if.life_lost), 32'd0);

        pulse_hit();
        check_all("invuln_hit", 2, 0, 1, 0);
        pulse_start();
        check_all("invuln_start", 2, 0, 1, 0);

        ticks(59);
        check("tick59.invuln", 32'(lm_if.invuln), 32'd1);
        ticks(1);
        check_all("tick60", 2, 0, 0, 0);

        // Hit and frame_tick together: tick must not shorten the window.
        lm_if.hit        = 1'b1;
        lm_if.frame_tick = 1'b1;
        step();
        clear_inputs();
        check_all("hit2_tick", 1, 0, 1, 1);
        ticks(59);
        check("hit2_tick59.invuln", 32'(lm_if.invuln), 32'd1);
        ticks(1);
        check_all("hit2_tick60", 1, 0, 0, 0);

        pulse_hit();
        check_all("hit3", 0, 1, 0, 1);
        step();
        check_all("over_hold", 0, 1, 0, 0);
        pulse_hit();
        check_all("over_hit", 0, 1, 0, 0);
        ticks(3);
        check_all("over_ticks", 0, 1, 0, 0);

        pulse_start();
        check_all("restart", 3, 0, 0, 0);

        pulse_hit();
        check_all("hit_r1", 2, 0, 1, 1);
        ticks(30);
        check("mid_invuln.invuln", 32'(lm_if.invuln), 32'd1);
        // Reset wins over a simultaneous hit: no residual life_lost.
        reset     = 1'b1;
        lm_if.hit = 1'b1;
        step();
        reset     = 1'b0;
        lm_if.hit = 1'b0;
        check_all("reset_invuln", 3, 0, 0, 0);
        pulse_hit();
        check_all("ready_after_reset", 3, 0, 0, 0);

        // Reset while in OVER.
        pulse_start();
        pulse_hit();
        ticks(60);
        pulse_hit();
        ticks(60);
        pulse_hit();
        check_all("over_again", 0, 1, 0, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_all("reset_over", 3, 0, 0, 0);

`ifdef EXTRA_LIFE_EN
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            lm_if.award_life = 1'b1;
            step();
            lm_if.award_life = 1'b0;
        end
        check_all("award_to7", 7, 0, 0, 0);
        lm_if.award_life = 1'b1;
        step();
        lm_if.award_life = 1'b0;
        check_all("award_sat", 7, 0, 0, 0);

        for (int i = 6; i >= 1; i--) begin
            pulse_hit();
            check($sformatf("down_%0d.lives", i), 32'(lm_if.lives), 32'(i));
            ticks(60);
        end
        check_all("at_one", 1, 0, 0, 0);
        lm_if.hit        = 1'b1;
        lm_if.award_life = 1'b1;
        step();
        clear_inputs();
        check_all("hit_award", 1, 0, 1, 1);
        lm_if.award_life = 1'b1;
        step();
        lm_if.award_life = 1'b0;
        check_all("award_invuln", 2, 0, 1, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
